// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS fetch front end.
//   fetch_state_t : fetch FSM states (S_IDLE, S_FETCH, S_FULL)
//   INSTR_W       : instruction word width
//   PC_INC        : byte increment between sequential fetches
//   fetch_entry_t : {pc, instr} layout of one instruction-FIFO entry at the
//                   default 32-bit PC width (the top packs the same layout
//                   at its own XLEN)
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;
   localparam int PC_W    = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_FULL
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous flush and occupancy count.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   flush      : empty the FIFO this cycle; overrides push and pop
//   push, din  : write din when not full (or when a pop frees a slot)
//   pop        : drop head entry; ignored when empty
//   dout       : head entry (undefined contents when empty)
//   count      : number of stored entries, 0..DEPTH
// DEPTH need not be a power of two; pointers wrap explicitly.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
// Instruction-fetch front end: issues pipelined, in-order requests to
// instruction memory, buffers returned words with their PC and presents
// them to decode. Handles decode stalls and branch/jump redirects, dropping
// responses to requests issued before a redirect.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   imemReq, imemAddr     : fetch request and word-aligned address
//   imemGnt               : memory accepts the request this cycle
//   imemRvalid, imemRdata : in-order response, >=1 cycle after grant
//   validD, instrD, pcD   : FIFO head to decode (zero when empty)
//   stallD                : decode not consuming this cycle
//   redirect, redirectPC  : taken branch/jump, new fetch PC
//   perfFetched, perfDropped, perfRedirects : 32-bit saturating event
//     counters, present only when IFETCH_PERF_EN is defined
//
// Optional feature macro: IFETCH_PERF_EN
// ---------------------------------------------------------------------------
module ifetch_buffer
   import mips_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              MAXOUT   = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imemReq,
   output logic [XLEN-1:0]    imemAddr,
   input  logic               imemGnt,
   input  logic               imemRvalid,
   input  logic [INSTR_W-1:0] imemRdata,
   output logic               validD,
   output logic [INSTR_W-1:0] instrD,
   output logic [XLEN-1:0]    pcD,
   input  logic               stallD,
   input  logic               redirect,
   input  logic [XLEN-1:0]    redirectPC
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]        perfFetched,
   output logic [31:0]        perfDropped,
   output logic [31:0]        perfRedirects
`endif
);

   localparam int OCNT_W  = $clog2(MAXOUT+1);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = XLEN + INSTR_W;

   fetch_state_t        state;
   fetch_state_t        state_nxt;
   logic [XLEN-1:0]     fetch_pc;
   logic [OCNT_W-1:0]   outstanding;   // in flight, live and stale
   logic [OCNT_W-1:0]   discard;       // stale responses still to drop
   logic [CNT_W-1:0]    count;
   logic [XLEN-1:0]     tag_head;
   logic [ENTRY_W-1:0]  head;
   logic                credit;
   logic                grant;
   logic                rsp;
   logic                drop;
   logic                push;
   logic                pop;

   // Reserve a FIFO slot for every live in-flight request so a response
   // can always be accepted.
   always_comb begin
      credit = (int'(outstanding) < MAXOUT) &&
               ((int'(outstanding) - int'(discard) + int'(count)) < DEPTH);
   end

   // A response with nothing outstanding is a protocol error: ignore it.
   always_comb begin
      rsp  = imemRvalid && (outstanding != '0);
      drop = rsp && (redirect || (discard != '0));
      push = rsp && !drop;
      pop  = validD && !stallD && !redirect;
   end

   // FSM: next state and request
   always_comb begin
      state_nxt = state;
      imemReq   = 1'b0;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: begin
            imemReq = credit && !redirect;
            if (!credit) state_nxt = S_FULL;
         end
         S_FULL:  if (credit) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
      if (redirect && (state != S_IDLE)) state_nxt = S_FETCH;
   end

   assign grant    = imemReq && imemGnt;
   assign imemAddr = fetch_pc;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= redirectPC;
         // Every request now in flight (live or already stale) is stale,
         // less the one whose response is being dropped this cycle.
         discard  <= outstanding - OCNT_W'(rsp);
      end else begin
         if (grant)                      fetch_pc <= fetch_pc + XLEN'(PC_INC);
         if (rsp && (discard != '0))     discard  <= discard - OCNT_W'(1);
      end
   end

   // PC tags of in-flight requests; its occupancy is the outstanding count.
   // Not flushed on redirect: stale responses still retire their tags.
   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAXOUT)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (1'b0),
      .push  (grant),
      .pop   (rsp),
      .din   (fetch_pc),
      .dout  (tag_head),
      .count (outstanding)
   );

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_instr_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   ({tag_head, imemRdata}),
      .dout  (head),
      .count (count)
   );

   assign validD = (count != '0);
   assign pcD    = validD ? head[ENTRY_W-1 -: XLEN] : '0;
   assign instrD = validD ? head[INSTR_W-1:0]       : '0;

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perfFetched   <= '0;
         perfDropped   <= '0;
         perfRedirects <= '0;
      end else begin
         if (push && (perfFetched != '1))       perfFetched   <= perfFetched + 32'd1;
         if (drop && (perfDropped != '1))       perfDropped   <= perfDropped + 32'd1;
         if (redirect && (perfRedirects != '1)) perfRedirects <= perfRedirects + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_buffer
// Directed scenarios followed by a randomized run. The reference model is
// an in-order memory (queue of pending responses) plus the expected
// instruction stream: decode must see consecutive PCs starting at the reset
// PC or the latest redirect target, each with the word memory holds there.
// ---------------------------------------------------------------------------
module tb_ifetch_buffer;

   localparam int          DEPTH    = 4;
   localparam int          MAXOUT   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        validD;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic        stallD;
   logic        redirect;
   logic [31:0] redirectPC;
`ifdef IFETCH_PERF_EN
   logic [31:0] perfFetched, perfDropped, perfRedirects;
`endif

   ifetch_buffer #(
      .XLEN(32), .DEPTH(DEPTH), .MAXOUT(MAXOUT), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .reset(reset),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
      .imemRvalid(imemRvalid), .imemRdata(imemRdata),
      .validD(validD), .instrD(instrD), .pcD(pcD),
      .stallD(stallD), .redirect(redirect), .redirectPC(redirectPC)
`ifdef IFETCH_PERF_EN
      , .perfFetched(perfFetched), .perfDropped(perfDropped), .perfRedirects(perfRedirects)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] data; } rsp_t;
   rsp_t memq[$];

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc, first_req, first_valid, n_gnt, n_deliv;
   logic [31:0] exp_pc, exp_fetch, last_gnt;
   bit   prev_redir, wrap_seen;
   // stimulus knobs
   int gnt_pct = 100, rv_pct = 100, stall_pct = 0, redir_pm = 0;
   int lat_min = 1, lat_max = 1;
   bit force_redir = 0, stale_rv = 0;
   logic [31:0] force_pc = 0;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input bit stale);
      reset = 1'b1; imemGnt = 1'b0; imemRvalid = stale; imemRdata = 32'hDEAD_BEEF;
      stallD = 1'b0; redirect = 1'b0; redirectPC = '0;
      @(posedge clk); #1;
      chk("rst_imemReq", imemReq, 0);
      chk("rst_validD", validD, 0);
      chk("rst_instrD", instrD, 0);
      chk("rst_pcD", pcD, 0);
      reset = 1'b0; imemRvalid = 1'b0;
      memq.delete();
      cyc = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC; prev_redir = 0;
      first_req = -1; first_valid = -1; n_gnt = 0; n_deliv = 0; last_gnt = 32'h1;
   endtask

   // One clock cycle, entered and left 1 time unit after a rising edge.
   task automatic cycle();
      int lat;
      bit rv;
      if (validD && first_valid < 0) first_valid = cyc;
      if (validD) begin
         chk("pcD", pcD, exp_pc);
         chk("instrD", instrD, memword(exp_pc));
      end else begin
         chk("empty_pcD", pcD, 0);
         chk("empty_instrD", instrD, 0);
      end
      stallD     = ($urandom_range(99) < stall_pct);
      redirect   = force_redir || ($urandom_range(999) < redir_pm);
      redirectPC = force_redir ? force_pc : ($urandom() & 32'hFFFF_FFFC);
      imemGnt    = ($urandom_range(99) < gnt_pct);
      rv = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
      imemRvalid = rv || stale_rv;
      imemRdata  = rv ? memq[0].data : 32'hBAD0_0BAD;
      #1;
      if (redirect) chk("req_on_redirect", imemReq, 0);
      if (imemReq && first_req < 0) first_req = cyc;
      if (validD && !stallD && !redirect) begin
         exp_pc += 32'd4;
         n_deliv++;
      end
      if (imemReq && imemGnt) begin
         chk("imemAddr", imemAddr, exp_fetch);
         if (last_gnt == 32'hFFFF_FFFC && imemAddr == 32'h0) wrap_seen = 1;
         last_gnt = imemAddr;
         lat = $urandom_range(lat_max, lat_min);
         memq.push_back('{due: cyc + lat, data: memword(imemAddr)});
         exp_fetch += 32'd4;
         n_gnt++;
      end
      if (rv) void'(memq.pop_front());
      if (redirect) begin
         exp_pc    = redirectPC;
         exp_fetch = redirectPC;
      end
      chk("outstanding_le_max", memq.size() <= MAXOUT, 1);
      prev_redir = redirect;
      @(posedge clk); #1;
      cyc++;
      if (prev_redir) chk("flush_after_redirect", validD, 0);
   endtask

   initial begin
      int k;
      bit ok;

      // 1. Always-grant, 1-cycle memory: first request cycle 1, first
      //    instruction cycle 3, then one per cycle.
      do_reset(0);
      repeat (12) cycle();
      chk("first_req_cycle", first_req, 1);
      chk("first_valid_cycle", first_valid, 3);
      chk("sustained_rate", n_deliv, 9);

      // 2. Decode stalled: FIFO fills to DEPTH, requests stop, nothing lost.
      do_reset(0);
      stall_pct = 100;
      repeat (12) cycle();
      chk("stall_grants", n_gnt, DEPTH);
      chk("stall_imemReq", imemReq, 0);
      chk("stall_outstanding", memq.size(), 0);
      chk("stall_validD", validD, 1);
      stall_pct = 0;
      repeat (20) cycle();
      chk("stall_release", n_deliv >= 16, 1);

      // 3. Redirect to 0x100 with two requests in flight.
      do_reset(0);
      lat_min = 3; lat_max = 3;
      k = 0;
      while (memq.size() < 2 && k < 10) begin cycle(); k++; end
      chk("redir_setup", memq.size(), 2);
      force_redir = 1; force_pc = 32'h100;
      cycle();
      force_redir = 0;
      k = 0;
      while (!validD && k < 20) begin cycle(); k++; end
      chk("redir_first_valid", validD, 1);
      chk("redir_first_pc", pcD, 32'h100);

      // 4. Redirect in the same cycle as a response, decode not stalled.
      lat_min = 2; lat_max = 2;
      k = 0;
      ok = 0;
      while (!ok && k < 30) begin
         ok = validD && (memq.size() > 0) && (memq[0].due <= cyc);
         if (!ok) begin cycle(); k++; end
      end
      chk("rv_redir_setup", ok, 1);
      force_redir = 1; force_pc = 32'h200;
      cycle();
      force_redir = 0;
      chk("rv_redir_empty", validD, 0);
      k = 0;
      while (!validD && k < 20) begin cycle(); k++; end
      chk("rv_redir_first_pc", pcD, 32'h200);
      repeat (8) cycle();

      // 5. Fetch address wraps past 0xFFFF_FFFC.
      lat_min = 1; lat_max = 1;
      wrap_seen = 0;
      force_redir = 1; force_pc = 32'hFFFF_FFF8;
      cycle();
      force_redir = 0;
      repeat (10) cycle();
      chk("addr_wrap", wrap_seen, 1);

      // 6. Reset with two requests in flight; responses arrive during reset
      //    and in the idle cycle after it.
      lat_min = 3; lat_max = 3;
      k = 0;
      while (memq.size() < 2 && k < 10) begin cycle(); k++; end
      chk("rst_mid_setup", memq.size(), 2);
      lat_min = 1; lat_max = 1;
      do_reset(1);
      stale_rv = 1;
      cycle();
      stale_rv = 0;
      repeat (8) cycle();
      chk("rst_mid_first_req", first_req, 1);
      chk("rst_mid_first_valid", first_valid, 3);

      // 7. Randomized traffic.
      do_reset(0);
      gnt_pct = 70; rv_pct = 70; stall_pct = 30; redir_pm = 30;
      lat_min = 1; lat_max = 4;
      repeat (3000) cycle();
      chk("random_progress", n_deliv >= 200, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
